instr_fetch: RTL and testbench

- Instruction fetch sequencer directly upstream of the micro-op decode table.
- Reads opcode bytes, plus an immediate byte where the opcode needs one, from byte-wide program memory.
- Presents one 8-bit `instruction` per issue slot, with its immediate in `imm_data`.
- Executes jump-to-immediate (0x80) and halt (0xFE) locally by redirecting or freezing the instruction pointer.

---
 rtl/instr_fetch.sv | 140 ++++++++++++++
 tb/tb_instr_fetch.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads opcode (+ optional immediate) bytes from program memory,
// issues one registered instruction per slot, and executes jump (0x80) / halt (0xFE) locally.
// Optional feature macro: SINGLE_STEP_EN adds a `step` input that gates each opcode fetch.
module instr_fetch #(
  parameter int              ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_IP = '0,
  parameter logic [7:0]      NOP_OP   = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              mem_valid,
  input  logic              stall,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [7:0]        instruction,
  output logic [7:0]        imm_data,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] ip,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH_OP,
    S_WAIT_OP,
    S_FETCH_IMM,
    S_WAIT_IMM,
    S_ISSUE,
    S_HALT
  } state_t;

  localparam logic [7:0] OP_JUMP = 8'h80;
  localparam logic [7:0] OP_HALT = 8'hFE;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_ip;
  logic [7:0]        r_opcode;
  logic [7:0]        r_imm;
  logic [7:0]        r_instruction;
  logic [7:0]        r_imm_data;
  logic              r_instr_valid;
  logic              w_mem_rd;
  logic              w_fetch_go;

  function automatic logic f_has_imm(input logic [7:0] op);
    return (op[7:3] == 5'b00000) || (op[7:6] == 2'b01) || (op == OP_JUMP);
  endfunction

`ifdef SINGLE_STEP_EN
  assign w_fetch_go = step;
`else
  assign w_fetch_go = 1'b1;
`endif

  // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    w_mem_rd     = 1'b0;
    unique case (r_state)
      S_FETCH_OP: begin
        if (w_fetch_go) begin
          w_mem_rd     = 1'b1;
          w_next_state = S_WAIT_OP;
        end
      end
      S_WAIT_OP: begin
        if (mem_valid)
          w_next_state = f_has_imm(mem_data) ? S_FETCH_IMM : S_ISSUE;
      end
      S_FETCH_IMM: begin
        w_mem_rd     = 1'b1;
        w_next_state = S_WAIT_IMM;
      end
      S_WAIT_IMM: begin
        if (mem_valid) w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        if (!stall) w_next_state = (r_opcode == OP_HALT) ? S_HALT : S_FETCH_OP;
      end
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_FETCH_OP;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_FETCH_OP;
      r_ip          <= RESET_IP;
      r_opcode      <= '0;
      r_imm         <= '0;
      r_instruction <= NOP_OP;
      r_imm_data    <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_instruction <= NOP_OP;
      r_imm_data    <= '0;
      r_instr_valid <= 1'b0;
      unique case (r_state)
        S_WAIT_OP: begin
          if (mem_valid) begin
            r_opcode <= mem_data;
            r_imm    <= '0;
            r_ip     <= r_ip + ADDR_W'(1);
          end
        end
        S_WAIT_IMM: begin
          if (mem_valid) begin
            r_imm <= mem_data;
            r_ip  <= r_ip + ADDR_W'(1);
          end
        end
        S_ISSUE: begin
          if (!stall) begin
            r_instruction <= r_opcode;
            r_imm_data    <= r_imm;
            r_instr_valid <= 1'b1;
            if (r_opcode == OP_JUMP) r_ip <= ADDR_W'(r_imm);
          end
        end
        default: ;
      endcase
    end
  end

  // Read strobe is held low while reset is asserted even though the state already reads FETCH_OP.
  assign mem_rd      = rst_n & w_mem_rd;
  assign mem_addr    = mem_rd ? r_ip : '0;
  assign instruction = r_instruction;
  assign imm_data    = r_imm_data;
  assign instr_valid = r_instr_valid;
  assign ip          = r_ip;
  assign halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch (default build, SINGLE_STEP_EN undefined).
// A one-cycle-latency program memory model responds to mem_rd; issues and reads are logged.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_data = 8'h00;
  logic       mem_valid = 1'b0;
  logic       stall = 1'b0;
  logic [7:0] instruction;
  logic [7:0] imm_data;
  logic       instr_valid;
  logic [7:0] ip;
  logic       halted;

  instr_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_valid  (mem_valid),
    .stall      (stall),
    .instruction(instruction),
    .imm_data   (imm_data),
    .instr_valid(instr_valid),
    .ip         (ip),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  bit         pend;
  logic [7:0] pend_addr;
  int         cyc;
  int         errors;
  int         checks;
  int         nop_bad;
  int         halt_bad;
  logic [7:0] iss_op[$];
  logic [7:0] iss_imm[$];
  logic [7:0] iss_ip[$];
  int         iss_cyc[$];
  logic [7:0] rd_addr[$];
  int         rd_cyc[$];

  // Monitor first, then memory model, so sampling order is fixed within the negedge.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (instr_valid) begin
        iss_op.push_back(instruction);
        iss_imm.push_back(imm_data);
        iss_ip.push_back(ip);
        iss_cyc.push_back(cyc);
      end else if (instruction !== 8'hFF || imm_data !== 8'h00) begin
        nop_bad++;
      end
      if (mem_rd) begin
        rd_addr.push_back(mem_addr);
        rd_cyc.push_back(cyc);
      end
      if (halted && mem_rd) halt_bad++;
    end
    mem_valid = pend;
    mem_data  = pend ? mem[pend_addr] : 8'h00;
    pend      = mem_rd;
    pend_addr = mem_addr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    iss_op.delete();
    iss_imm.delete();
    iss_ip.delete();
    iss_cyc.delete();
    rd_addr.delete();
    rd_cyc.delete();
    nop_bad  = 0;
    halt_bad = 0;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) mem[i] = 8'hFE;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    clear_logs();
    rst_n = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    fill_halt();

    // Reset state observed while rst_n is held low
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_instruction", instruction, 8'hFF);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_imm_data", imm_data, 8'h00);
    check("rst_ip", ip, 8'h00);
    check("rst_halted", halted, 1'b0);
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_mem_addr", mem_addr, 8'h00);

    // Single-byte instruction, then halt at address 1
    fill_halt();
    mem[0] = 8'h20;
    do_reset();
    run(12);
    check("t1_rd0", rd_addr[0], 8'h00);
    check("t1_rd1", rd_addr[1], 8'h01);
    check("t1_nissue", iss_op.size(), 2);
    check("t1_op", iss_op[0], 8'h20);
    check("t1_imm", iss_imm[0], 8'h00);
    check("t1_ip", iss_ip[0], 8'h01);
    check("t1_latency", iss_cyc[0] - rd_cyc[0], 3);
    check("t1_nop", nop_bad, 0);

    // Immediate-bearing instruction
    fill_halt();
    mem[0] = 8'h03;
    mem[1] = 8'h5A;
    do_reset();
    run(15);
    check("t2_rd0", rd_addr[0], 8'h00);
    check("t2_rd1", rd_addr[1], 8'h01);
    check("t2_rd2", rd_addr[2], 8'h02);
    check("t2_op", iss_op[0], 8'h03);
    check("t2_imm", iss_imm[0], 8'h5A);
    check("t2_ip", iss_ip[0], 8'h02);
    check("t2_latency", iss_cyc[0] - rd_cyc[0], 5);
    check("t2_nissue", iss_op.size(), 2);
    check("t2_nop", nop_bad, 0);

    // Jump to 0x10, then single-byte instruction there
    fill_halt();
    mem[0]     = 8'h80;
    mem[1]     = 8'h10;
    mem[8'h10] = 8'h21;
    do_reset();
    run(25);
    check("t3_op0", iss_op[0], 8'h80);
    check("t3_imm0", iss_imm[0], 8'h10);
    check("t3_ip0", iss_ip[0], 8'h10);
    check("t3_rd2", rd_addr[2], 8'h10);
    check("t3_op1", iss_op[1], 8'h21);
    check("t3_imm1", iss_imm[1], 8'h00);
    check("t3_ip1", iss_ip[1], 8'h11);

    // Opcode at 0xFF, immediate wraps to address 0x00
    fill_halt();
    mem[0]     = 8'h07;
    mem[1]     = 8'h00;
    mem[2]     = 8'h80;
    mem[3]     = 8'hFF;
    mem[8'hFF] = 8'h40;
    do_reset();
    run(30);
    check("t4_op0", iss_op[0], 8'h07);
    check("t4_ip0", iss_ip[0], 8'h02);
    check("t4_ip1", iss_ip[1], 8'hFF);
    check("t4_rd_op", rd_addr[4], 8'hFF);
    check("t4_rd_imm", rd_addr[5], 8'h00);
    check("t4_op2", iss_op[2], 8'h40);
    check("t4_imm2", iss_imm[2], 8'h07);
    check("t4_ip2", iss_ip[2], 8'h01);

    // Stall held for four ISSUE cycles
    fill_halt();
    mem[0] = 8'h20;
    stall  = 1'b1;
    do_reset();
    run(6);
    stall = 1'b0;
    run(10);
    check("t5_nissue", iss_op.size(), 2);
    check("t5_op", iss_op[0], 8'h20);
    check("t5_latency", iss_cyc[0] - rd_cyc[0], 7);
    check("t5_op_next", iss_op[1], 8'hFE);
    check("t5_nop", nop_bad, 0);

    // Halt: issued once, then frozen with no reads
    fill_halt();
    do_reset();
    run(25);
    check("t6_nissue", iss_op.size(), 1);
    check("t6_op", iss_op[0], 8'hFE);
    check("t6_halted", halted, 1'b1);
    check("t6_nreads", rd_addr.size(), 1);
    check("t6_halt_rd", halt_bad, 0);
    check("t6_ip", ip, 8'h01);

    // Reset mid-WAIT_OP while mem_valid is high: the read is dropped
    fill_halt();
    mem[0] = 8'h20;
    do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    check("t7_ip", ip, 8'h00);
    check("t7_valid", instr_valid, 1'b0);
    check("t7_instruction", instruction, 8'hFF);
    check("t7_halted", halted, 1'b0);
    check("t7_mem_rd_in_rst", mem_rd, 1'b0);
    clear_logs();
    rst_n = 1'b1;
    #1;
    check("t7_mem_rd_after", mem_rd, 1'b1);
    check("t7_mem_addr_after", mem_addr, 8'h00);
    run(12);
    check("t7_op", iss_op[0], 8'h20);
    check("t7_ip_issue", iss_ip[0], 8'h01);
    check("t7_nissue", iss_op.size(), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
